joy_serializer: RTL

// - Board-side counterpart of the joystick decoder: emulates the two cascaded
//   74HC165 parallel-in/serial-out registers that feed joy_data.
// - Samples 16 button lines (two 8-bit ports) into a shift register while
//   joy_load_n is low. Shifts them out MSB-first on each joy_clk rising edge.
// - Used in simulation benches and on boards where the FPGA reads pads directly.

---
 rtl/joy_serializer_pkg.sv | 35 +++
 rtl/joy_serializer_sync_edge.sv | 44 ++++
 rtl/joy_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/joy_serializer_pkg.sv
// joy_serializer_pkg
// Shared constants for the joystick serializer slice.
//   JOY_BITS_PER_PORT   buttons per joystick port
//   JOY_IDX_*           bit position of each button inside one port
//                       (up is the MSB, start is the LSB)
//   JOY_PORT1_MSB       bit index of joy1 "up" within the 16-bit pad vector
//   ser_mode_e          the two implicit operating modes of the serializer
//   joy_pad_index()     maps (port, button index) to a pad vector bit
package joy_serializer_pkg;

  localparam int JOY_BITS_PER_PORT = 8;

  localparam int JOY_IDX_UP    = 7;
  localparam int JOY_IDX_DOWN  = 6;
  localparam int JOY_IDX_LEFT  = 5;
  localparam int JOY_IDX_RIGHT = 4;
  localparam int JOY_IDX_FIRE1 = 3;
  localparam int JOY_IDX_FIRE2 = 2;
  localparam int JOY_IDX_FIRE3 = 1;
  localparam int JOY_IDX_START = 0;

  localparam int JOY_PORT1_MSB = 15;

  // LOAD follows the pads transparently, SHIFT moves bits out on joy_clk.
  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_SHIFT = 1'b1
  } ser_mode_e;

  // Port 1 occupies the upper byte of the pad vector, port 2 the lower byte.
  function automatic int joy_pad_index(input int port, input int idx);
    return (port == 1) ? (JOY_BITS_PER_PORT + idx) : idx;
  endfunction

endpackage

// File: rtl/joy_serializer_sync_edge.sv
// sync_edge
// N-stage synchronizer for one asynchronous control line, plus single-cycle
// rise/fall strobes derived from the synchronized level.
//   clk, rst_n   system clock, asynchronous active-low reset
//   din          asynchronous input
//   level        synchronized level (last synchronizer stage)
//   rise, fall   combinational strobes, high for one clk cycle per edge
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronizer chain plus one extra flop holding the previous synchronized
  // level; the edge strobes compare the two. Everything resets to RESET_VAL
  // so no edge is reported when reset releases with the line idle at that
  // value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/joy_serializer.sv
// joy_serializer
// Emulates two cascaded 74HC165 parallel-in/serial-out registers so the
// joystick decoder can be exercised against pads read directly by the FPGA.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pads_n       raw active-low button lines, [15:8] joy1, [7:0] joy2
//   joy_clk      shift clock from the decoder (asynchronous)
//   joy_load_n   parallel load from the decoder, active-low (asynchronous)
//   joy_data     registered serial output (QH of the chain)
//   frame_stb    one-cycle pulse when the load is released
//   overrun      sticky flag: more than WIDTH-1 shifts in one frame
module joy_serializer
  import joy_serializer_pkg::*;
#(
  parameter int   WIDTH       = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic SER_FILL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pads_n,
  input  logic             joy_clk,
  input  logic             joy_load_n,
  output logic             joy_data,
  output logic             frame_stb,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             load_level;
  logic             load_rise;
  logic             load_fall;
  logic             clk_level;
  logic             clk_rise;
  logic             clk_fall;
  logic             unused_edges;
  logic [WIDTH-1:0] pad_chain [SYNC_STAGES];
  logic [WIDTH-1:0] pads_sync;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] shift_cnt;
  ser_mode_e        mode;

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_load (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (joy_load_n),
    .level (load_level),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (joy_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Falling edges of joy_clk and the load assertion carry no meaning here.
  assign unused_edges = load_fall ^ clk_fall ^ clk_level;

  // Plain vector synchronizer for the pads; the buttons are slow and only
  // sampled while the load is held, so no edge detection is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pad_chain[i] <= '1;
      end
    end else begin
      pad_chain[0] <= pads_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pad_chain[i] <= pad_chain[i-1];
      end
    end
  end

  assign pads_sync = pad_chain[SYNC_STAGES-1];

  // The synchronized load level alone picks the mode, just like the real
  // part: held low it is a transparent latch of the pads.
  assign mode = load_level ? MODE_SHIFT : MODE_LOAD;

  // Shift register, shift counter and status flags.
  // In LOAD the register follows the pads and the count restarts. In SHIFT,
  // the cycle that sees the load released is reserved for starting the new
  // frame (strobe and overrun clear); a joy_clk edge landing on that same
  // sample is deliberately dropped so the first bit stays pads[MSB].
  // The count saturates at WIDTH; a shift arriving once WIDTH-1 shifts have
  // already happened means the decoder clocked past the end of the chain.
  // joy_data is re-registered from the MSB every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '1;
      shift_cnt <= '0;
      joy_data  <= 1'b1;
      frame_stb <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      joy_data  <= sreg[WIDTH-1];
      frame_stb <= load_rise;
      case (mode)
        MODE_LOAD: begin
          sreg      <= pads_sync;
          shift_cnt <= '0;
        end
        MODE_SHIFT: begin
          if (load_rise) begin
            overrun <= 1'b0;
          end else if (clk_rise) begin
            sreg <= {sreg[WIDTH-2:0], SER_FILL};
            if (shift_cnt != CNT_W'(WIDTH)) begin
              shift_cnt <= shift_cnt + 1'b1;
            end
            if (shift_cnt >= CNT_W'(WIDTH - 1)) begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          sreg <= sreg;
        end
      endcase
    end
  end

endmodule
